// File: rtl/regfile_writeback.sv
// Regfile writeback arbiter: loads own the single write port, ALU results bypass
// or queue in a DEPTH-entry FIFO, and pending results are visible through forwarding.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [4:0]              mem_rd,
  input  logic [DATA_W-1:0]       mem_data,
  output logic [4:0]              reg_wa,
  output logic [DATA_W-1:0]       wa_data,
  output logic                    reg_r_w,
  input  logic [4:0]              fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data,
  output logic [$clog2(DEPTH):0]  pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]        fifo_rd_q   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        reg_wa_q, reg_wa_d;
  logic [DATA_W-1:0] wa_data_q, wa_data_d;
  logic              reg_r_w_q, reg_r_w_d;
  logic              alu_live_s, mem_live_s, fifo_empty_s, push_s, pop_s, bypass_s;

  assign alu_ready = (count_q != FULL_CNT);
  assign pending   = count_q;
  assign reg_wa    = reg_wa_q;
  assign wa_data   = wa_data_q;
  assign reg_r_w   = reg_r_w_q;

  // Write-port arbitration: load, then FIFO head, then ALU bypass of an empty FIFO.
  always_comb begin
    alu_live_s   = alu_valid && alu_ready && (alu_rd != 5'd0);
    mem_live_s   = mem_valid && (mem_rd != 5'd0);
    fifo_empty_s = (count_q == {CW{1'b0}});
    pop_s        = !mem_live_s && !fifo_empty_s;
    bypass_s     = !mem_live_s && fifo_empty_s && alu_live_s;
    push_s       = alu_live_s && !bypass_s;
    wr_ptr_d     = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    if (mem_live_s) begin
      reg_wa_d  = mem_rd;
      wa_data_d = mem_data;
      reg_r_w_d = 1'b1;
    end else if (pop_s) begin
      reg_wa_d  = fifo_rd_q[rd_ptr_q];
      wa_data_d = fifo_data_q[rd_ptr_q];
      reg_r_w_d = 1'b1;
    end else if (bypass_s) begin
      reg_wa_d  = alu_rd;
      wa_data_d = alu_data;
      reg_r_w_d = 1'b1;
    end else begin
      reg_wa_d  = reg_wa_q;
      wa_data_d = wa_data_q;
      reg_r_w_d = 1'b0;
    end
  end

  // Control and output register state; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      reg_wa_q  <= 5'd0;
      wa_data_q <= {DATA_W{1'b0}};
      reg_r_w_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      reg_wa_q  <= reg_wa_d;
      wa_data_q <= wa_data_d;
      reg_r_w_q <= reg_r_w_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q so they need no reset.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      fifo_rd_q[wr_ptr_q]   <= alu_rd;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end else begin
      fifo_rd_q[wr_ptr_q]   <= fifo_rd_q[wr_ptr_q];
      fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
    end
  end

  // Forwarding: output register is lowest priority, then FIFO oldest to youngest so the youngest overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    if (fwd_addr != 5'd0) begin
      if (reg_r_w_q && (reg_wa_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wa_data_q;
      end else begin
        fwd_hit  = 1'b0;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if ((CW'(i) < count_q) && (fifo_rd_q[wr_ptr_q - AW'(i + 1)] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_data_q[wr_ptr_q - AW'(i + 1)];
        end else begin
          fwd_data = fwd_data;
        end
      end
    end else begin
      fwd_hit = 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic checked
// against a queue-based model of the writeback rules.
module tb_regfile_writeback;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [4:0]        reg_wa;
  logic [DATA_W-1:0] wa_data;
  logic              reg_r_w;
  logic [4:0]        fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [2:0]        pending;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_wa(reg_wa), .wa_data(wa_data), .reg_r_w(reg_r_w),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_data;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic        hit;
    logic [31:0] fd;
    hit = 1'b0;
    fd  = 32'd0;
    if (fwd_addr != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].rd == fwd_addr) begin
          hit = 1'b1;
          fd  = q[i].data;
        end
      end
      if (!hit && m_we && m_wa == fwd_addr) begin
        hit = 1'b1;
        fd  = m_data;
      end
    end
    chk("alu_ready", 32'(alu_ready), 32'(q.size() < DEPTH));
    chk("pending",   32'(pending),   32'(q.size()));
    chk("reg_r_w",   32'(reg_r_w),   32'(m_we));
    chk("reg_wa",    32'(reg_wa),    32'(m_wa));
    chk("wa_data",   wa_data,        m_data);
    chk("fwd_hit",   32'(fwd_hit),   32'(hit));
    chk("fwd_data",  fwd_data,       fd);
  endtask

  // Applies the writeback rules for the edge that just occurred.
  task automatic model_step();
    entry_t e;
    logic   acc;
    acc = alu_valid && (q.size() < DEPTH) && (alu_rd != 5'd0);
    e.rd = alu_rd;
    e.data = alu_data;
    if (!reset) begin
      q.delete();
      m_we = 1'b0; m_wa = 5'd0; m_data = 32'd0;
    end else if (mem_valid && mem_rd != 5'd0) begin
      m_we = 1'b1; m_wa = mem_rd; m_data = mem_data;
      if (acc) q.push_back(e);
    end else if (q.size() > 0) begin
      entry_t h;
      h = q.pop_front();
      m_we = 1'b1; m_wa = h.rd; m_data = h.data;
      if (acc) q.push_back(e);
    end else if (acc) begin
      m_we = 1'b1; m_wa = alu_rd; m_data = alu_data;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic cycle(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat, input logic [4:0] fa);
    @(negedge clk);
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat; fwd_addr = fa;
    #1;
    check_model();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    reset = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0; fwd_addr = 5'd0;
    repeat (2) @(posedge clk);
    q.delete();
    m_we = 1'b0; m_wa = 5'd0; m_data = 32'd0;
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);

    // Lone ALU write bypasses the empty FIFO
    cycle(1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 5'd5);
    #1;
    chk("lone_we",   32'(reg_r_w), 32'd1);
    chk("lone_wa",   32'(reg_wa),  32'd5);
    chk("lone_data", wa_data,      32'hA5A5A5A5);
    chk("lone_pend", 32'(pending), 32'd0);

    // Load and ALU in the same cycle
    cycle(1'b1, 1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 5'd4);
    #1;
    chk("conf1_wa",   32'(reg_wa), 32'd3);
    chk("conf1_data", wa_data,     32'h11);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    #1;
    chk("conf2_wa",   32'(reg_wa),  32'd4);
    chk("conf2_data", wa_data,      32'h22);
    chk("conf2_we",   32'(reg_r_w), 32'd1);

    // Fill the FIFO while loads hold the port, then drain in order
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'd1, 32'(i), 5'd0);
    #1;
    chk("full_pend",  32'(pending),   32'(DEPTH));
    chk("full_ready", 32'(alu_ready), 32'd0);
    cycle(1'b1, 1'b1, 5'd20, 32'd999, 1'b1, 5'd1, 32'd9, 5'd0);
    #1;
    chk("full_hold", 32'(pending), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12);
      #1;
      chk("drain_wa",    32'(reg_wa),    32'(10 + i));
      chk("drain_data",  wa_data,        32'(100 + i));
      chk("drain_ready", 32'(alu_ready), 32'd1);
    end

    // x0 destination is discarded
    cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0);
    #1;
    chk("x0_we",   32'(reg_r_w), 32'd0);
    chk("x0_pend", 32'(pending), 32'd0);
    chk("x0_fwd",  32'(fwd_hit), 32'd0);

    // Youngest of two pending r7 results forwards
    cycle(1'b1, 1'b1, 5'd7, 32'h1, 1'b1, 5'd2, 32'h50, 5'd7);
    cycle(1'b1, 1'b1, 5'd7, 32'h2, 1'b1, 5'd2, 32'h51, 5'd7);
    #1;
    chk("fwd7_hit",  32'(fwd_hit), 32'd1);
    chk("fwd7_data", fwd_data,     32'h2);

    // Reset with three entries pending
    cycle(1'b1, 1'b1, 5'd9, 32'h3, 1'b1, 5'd2, 32'h52, 5'd9);
    #1;
    chk("rst_pre_pend", 32'(pending), 32'd3);
    cycle(1'b0, 1'b1, 5'd8, 32'h4, 1'b1, 5'd6, 32'h53, 5'd7);
    #1;
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_we",   32'(reg_r_w), 32'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
    #1;
    chk("rst_after_we", 32'(reg_r_w), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic rst_r, av_r, mv_r;
      rst_r = ($urandom_range(0, 99) != 0);
      av_r  = ($urandom_range(0, 9) < 6);
      mv_r  = ($urandom_range(0, 9) < 4);
      cycle(rst_r, av_r, 5'($urandom_range(0, 7)), $urandom,
            mv_r, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
